leds: RTL and testbench

//  - Two-digit multiplexed 7-segment display driver for the board's common-anode display.
//  - Takes a 14-bit status word from the datapath as two 7-bit digit fields:

---
 rtl/leds_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 33 +++
 rtl/leds.sv | 71 +++++++
 tb/tb_leds.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared widths and glyph constants for the two-digit 7-segment driver.
// A glyph is ordered {a,b,c,d,e,f,g}, and a 1 bit means the segment is lit.
package leds_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 7;

  localparam logic [SEG_W-1:0] GLYPH_0    = 7'b1111110;
  localparam logic [SEG_W-1:0] GLYPH_1    = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_2    = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_3    = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_4    = 7'b0110011;
  localparam logic [SEG_W-1:0] GLYPH_5    = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_6    = 7'b1011111;
  localparam logic [SEG_W-1:0] GLYPH_7    = 7'b1110000;
  localparam logic [SEG_W-1:0] GLYPH_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9    = 7'b1111011;
  localparam logic [SEG_W-1:0] GLYPH_A    = 7'b1110111;
  localparam logic [SEG_W-1:0] GLYPH_B    = 7'b0011111;
  localparam logic [SEG_W-1:0] GLYPH_C    = 7'b1001110;
  localparam logic [SEG_W-1:0] GLYPH_D    = 7'b0111101;
  localparam logic [SEG_W-1:0] GLYPH_E    = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_F    = 7'b1000111;
  localparam logic [SEG_W-1:0] GLYPH_DASH = 7'b0000001;

  // Pin-level value, meaning all segments are dark.
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    SEL_RIGHT = 1'b0,
    SEL_LEFT  = 1'b1
  } sel_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decoder that maps a 7-bit digit code to an active-high glyph.
// Codes 0..15 give hex glyphs, and every larger code gives a dash.
module seg7_decode
  import leds_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [SEG_W-1:0]   glyph
);

  always_comb begin
    glyph = GLYPH_DASH;
    case (code)
      7'd0:    glyph = GLYPH_0;
      7'd1:    glyph = GLYPH_1;
      7'd2:    glyph = GLYPH_2;
      7'd3:    glyph = GLYPH_3;
      7'd4:    glyph = GLYPH_4;
      7'd5:    glyph = GLYPH_5;
      7'd6:    glyph = GLYPH_6;
      7'd7:    glyph = GLYPH_7;
      7'd8:    glyph = GLYPH_8;
      7'd9:    glyph = GLYPH_9;
      7'd10:   glyph = GLYPH_A;
      7'd11:   glyph = GLYPH_B;
      7'd12:   glyph = GLYPH_C;
      7'd13:   glyph = GLYPH_D;
      7'd14:   glyph = GLYPH_E;
      7'd15:   glyph = GLYPH_F;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/leds.sv
// Two-digit multiplexed common-anode 7-segment driver. Segment lines and anodes are active-low.
// The module has no handshake: Signal is sampled on every cycle, and the pins are free-running outputs.
module leds
  import leds_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [13:0] Signal,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        AN1,
  output logic        AN0
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [1:0]         rst_sync;
  logic               rst_s;
  logic [CNT_W-1:0]   cnt;
  sel_e               sel;
  logic [1:0]         an_q;
  logic [SEG_W-1:0]   seg_q;
  logic [DIGIT_W-1:0] code;
  logic [SEG_W-1:0]   glyph;

  // Assertion of the reset takes effect at once. Release passes through two flops first.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_s = rst_sync[1];

  assign code = (sel == SEL_LEFT) ? Signal[13:7] : Signal[6:0];

  seg7_decode u_decode (
    .code  (code),
    .glyph (glyph)
  );

  // The outputs are driven from the current select. This makes the anode and its segments switch on the same edge.
  always_ff @(posedge CLK or negedge rst_s) begin
    if (!rst_s) begin
      cnt   <= '0;
      sel   <= SEL_RIGHT;
      an_q  <= 2'b11;
      seg_q <= SEG_OFF;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        sel <= (sel == SEL_LEFT) ? SEL_RIGHT : SEL_LEFT;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an_q  <= (sel == SEL_LEFT) ? 2'b01 : 2'b10;
      seg_q <= ~glyph;
    end
  end

  assign {AN1, AN0}          = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_leds.sv
// Bench for leds with REFRESH_DIV=4. On each cycle the driver pushes the expected pin value into a queue.
// A monitor checks that value against {AN1,AN0,a..g} at the negedge that follows.
module tb_leds;

  localparam int DIV = 4;
  localparam logic [8:0] DARK = 9'h1FF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [13:0] Signal = 14'h0;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic        AN1, AN0;
  logic [8:0]  pins;

  leds #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .Signal(Signal),
    .a(seg_a), .b(seg_b), .c(seg_c), .d(seg_d), .e(seg_e), .f(seg_f), .g(seg_g),
    .AN1(AN1), .AN0(AN0)
  );

  assign pins = {AN1, AN0, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  // Clock and cycle counter. A value of cyc == k means that posedge k has already happened.
  always #10 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  logic [8:0] exp_q[$];
  int         tag_q[$];
  int         compared = 0;
  int         mismatched = 0;
  int         base = 1 << 30;
  bit         rst_held = 1'b1;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [6:0] v);
    case (v)
      7'd0:  return 7'b1111110;
      7'd1:  return 7'b0110000;
      7'd2:  return 7'b1101101;
      7'd3:  return 7'b1111001;
      7'd4:  return 7'b0110011;
      7'd5:  return 7'b1011011;
      7'd6:  return 7'b1011111;
      7'd7:  return 7'b1110000;
      7'd8:  return 7'b1111111;
      7'd9:  return 7'b1111011;
      7'd10: return 7'b1110111;
      7'd11: return 7'b0011111;
      7'd12: return 7'b1001110;
      7'd13: return 7'b0111101;
      7'd14: return 7'b1001111;
      7'd15: return 7'b1000111;
      default: return 7'b0000001;
    endcase
  endfunction

  // Expected pins after edge cy, with s as the Signal held over that edge.
  // The first lit cycle is base, and each phase lasts DIV cycles starting with the right digit.
  function automatic logic [8:0] model(input int cy, input logic [13:0] s);
    if (rst_held || cy < base) return DARK;
    if ((((cy - base) / DIV) % 2) == 0) return {2'b10, ~glyph(s[6:0])};
    return {2'b01, ~glyph(s[13:7])};
  endfunction

  task automatic push(input int cy, input logic [8:0] v);
    tag_q.push_back(cy);
    exp_q.push_back(v);
  endtask

  // Monitor
  initial begin
    int t;
    logic [8:0] ev;
    forever begin
      @(negedge CLK);
      #1;
      while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
        t  = tag_q.pop_front();
        ev = exp_q.pop_front();
        if (t < cyc) begin
          compared++;
          mismatched++;
          $display("FAIL missed_sample for cyc %0d: got none expected %b", t, ev);
        end else begin
          check("pins", pins, ev);
        end
      end
      compared++;
      if (AN1 === 1'b0 && AN0 === 1'b0) begin
        mismatched++;
        $display("FAIL anode_overlap @cyc %0d: got AN1=%b AN0=%b expected not both 0", cyc, AN1, AN0);
      end
    end
  end

  // Driver tasks
  task automatic step(input logic [13:0] s);
    @(negedge CLK);
    Signal = s;
    push(cyc + 1, model(cyc + 1, s));
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST_N    = 1'b1;
    rst_held = 1'b0;
    base     = cyc + 3;
    push(cyc + 1, model(cyc + 1, Signal));
  endtask

  task automatic assert_rst_mid();
    @(negedge CLK);
    #3;
    RST_N    = 1'b0;
    rst_held = 1'b1;
    #1;
    check("reset_async_dark", pins, DARK);
    push(cyc + 1, DARK);
  endtask

  task automatic run_until_cyc(input int n);
    for (int i = 0; i < 40 && cyc < n; i++) step(Signal);
    if (cyc != n) check("run_until_cyc", 9'(cyc), 9'(n));
  endtask

  task automatic run_until_phase(input int ph);
    for (int i = 0; i < 10 && ((cyc - base) % 8) != ph; i++) step(Signal);
    if (((cyc - base) % 8) != ph) check("phase_align", 9'((cyc - base) % 8), 9'(ph));
  endtask

  initial begin
    logic [6:0] sweep [18];
    for (int i = 0; i < 16; i++) sweep[i] = 7'(i);
    sweep[16] = 7'd16;
    sweep[17] = 7'd127;

    // Reset is held: every output stays dark.
    for (int i = 0; i < 4; i++) step(14'b0000001_0000100);
    #2 check("reset_dark", pins, DARK);

    release_rst();
    run_until_cyc(base - 1);
    #2 check("pre_first_lit_dark", pins, DARK);
    step(Signal);
    #2 check("first_an0_digit4", pins, {2'b10, 7'b1001100});
    run_until_cyc(base + 4);
    #2 check("an1_digit1", pins, {2'b01, 7'b1001111});
    run_until_cyc(base + 20);

    // Signal changes partway through a phase. The right digit should show '9' one cycle later.
    step(14'h0084);
    run_until_phase(1);
    step(14'h0009);
    step(14'h0009);
    #2 check("midphase_digit9", pins, {2'b10, 7'b0000100});

    // Decode sweep. Both fields take the same value so that both phases get checked.
    for (int i = 0; i < 18; i++)
      for (int j = 0; j < 8; j++) step({sweep[i], sweep[i]});

    // Reset asserted during the left-digit phase.
    run_until_phase(5);
    assert_rst_mid();
    for (int i = 0; i < 3; i++) step(Signal);
    release_rst();
    run_until_cyc(base);
    #2 check("restart_an0_dash", pins, {2'b10, 7'b1111110});
    for (int i = 0; i < 10; i++) step(14'h0A05);

    @(negedge CLK);
    @(negedge CLK);
    #2;
    if (tag_q.size() != 0) check("queue_drained", 9'(tag_q.size()), 9'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
